me_sad_engine: RTL and testbench
================================

Name: me_sad_engine

Overview:
Parametrised block-matching SAD engine. It stores one BLK x BLK current block, then accepts row-serial search candidates. For each candidate it accumulates the SAD and tracks the minimum SAD and its candidate index. Successor to the fixed 16x16 datapath: adds generic pixel width, block size and candidate count, a valid/ready input handshake, per-candidate SAD output, and current-block reuse across searches.

Parameters:
PIX_W, 8, pixel width in bits
BLK, 16, block dimension (BLK x BLK pixels, one row per beat)
NUM_CAND, 289, candidates per search (17x17 window, +/-8)
POS_W, 10, candidate index width; must satisfy 2^POS_W >= NUM_CAND
SAD_W, 16, SAD width; must satisfy SAD_W >= PIX_W + clog2(BLK*BLK)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins an operation; honoured only in IDLE or DONE
reuse_cur  input  1  sampled with start; 1 = skip LOAD_CUR and reuse the stored current block
in_valid  input  1  in_data beat valid
in_ready  output  1  engine accepts a beat; transfer = in_valid & in_ready
in_data  input  PIX_W*BLK  one pixel row; pixel 0 in LSBs
sad_valid  output  1  one-cycle pulse; sad_out/sad_pos valid
sad_out  output  SAD_W  SAD of the just-completed candidate
sad_pos  output  POS_W  index of the just-completed candidate
best_sad  output  SAD_W  running minimum SAD
best_pos  output  POS_W  index of best_sad
done  output  1  high in DONE; best_* are final

Behaviour:
- Reset values: in_ready=0, sad_valid=0, sad_out=0, sad_pos=0, best_sad=all-ones, best_pos=0, done=0. FSM goes to IDLE. Row and candidate counters are 0. The stored current block is not cleared.
- Reset overrides everything. Reset mid-operation abandons the search and discards any partial accumulation.
- FSM states: IDLE, LOAD_CUR, SEARCH, DONE.
- IDLE/DONE + start:
  - best_sad <= all-ones, best_pos <= 0, done <= 0, counters <= 0.
  - Next state: SEARCH if reuse_cur=1, otherwise LOAD_CUR.
  - start in LOAD_CUR or SEARCH is ignored.
- LOAD_CUR:
  - in_ready=1. Each transfer writes row[row_cnt].
  - After row BLK-1 is accepted: go to SEARCH, row_cnt <= 0.
- SEARCH:
  - in_ready=1. Each transfer is row row_cnt of candidate cand_cnt.
  - rowsum = sum over i of |in_data[i] - cur[row_cnt][i]|, computed combinationally. Magnitudes are unsigned; no saturation is needed given the SAD_W constraint.
  - acc <= (row_cnt==0 ? 0 : acc) + rowsum.
- Candidate completion (transfer with row_cnt==BLK-1):
  - Next cycle: sad_valid=1, sad_out = final SAD, sad_pos = cand_cnt.
  - On the same edge, if final SAD < best_sad (strict): best_sad and best_pos update. Ties keep the earlier, lower index.
  - row_cnt <= 0 and cand_cnt increments.
  - If cand_cnt == NUM_CAND-1: go to DONE. in_ready drops in that same following cycle.
- Counter wrap: row_cnt wraps at BLK and cand_cnt at NUM_CAND. Neither passes through values outside those ranges.
- in_valid=0 stalls: state, counters and acc hold; there are no bubbles in the result stream.
- DONE: done=1, in_ready=0, best_* held until the next start or reset. In_data is ignored.
- Latency: final row accepted at cycle t → sad_valid and updated best_* at t+1, and done at t+1 for the last candidate. Throughput is 1 row per cycle, i.e. BLK cycles per candidate.
- in_valid is ignored in IDLE and DONE.

Optional Feature:
ME_EARLY_TERM_EN
- Defined:
  - Once the partial acc >= best_sad within a candidate, that candidate is pruned.
  - Its remaining rows are still accepted but not accumulated (adder input gated to 0, acc frozen).
  - At completion it reports sad_out = all-ones and never updates best_*.
  - Timing and the handshake are unchanged.
- Undefined: every candidate is fully accumulated and reports its true SAD.

Test Plan:
- Reset, then idle → in_ready=0, done=0, best_sad=16'hFFFF, best_pos=0, sad_valid never pulses.
- Current block all 8'h10, 4 candidates (NUM_CAND=4) with rows all 8'h10, 8'h12, 8'h10, 8'h0F → sad_out 0, 512, 0, 256; best_sad=0, best_pos=0 (tie keeps index 0); done one cycle after the last row.
- Random in_valid gaps (~50%) on the same data → identical sad_out/sad_pos sequence; one sad_valid per candidate.
- Second start with reuse_cur=1, no rows loaded, candidates all 8'h11 → every sad_out=256; best_pos=0.
- Reset asserted mid-candidate 2, then a fresh start with reuse_cur=1 → no stale acc; first sad_out correct; best_* re-initialised.
- ME_EARLY_TERM_EN defined, candidates 8'h10 then 8'hFF → candidate 1 sad_out=16'hFFFF, best_pos=0; undefined → sad_out=60928.

Source files
------------

// File: rtl/me_sad_engine.sv
// ---------------------------------------------------------------------------
// me_sad_engine -- parametrised block-matching SAD engine.
//
// The engine stores one BLK x BLK current block, loaded one row per beat.
// It then accepts row-serial search candidates and accumulates the sum of
// absolute differences for each one. It tracks the minimum SAD and the index
// of the candidate that produced it. A search can reuse the stored current
// block by skipping the load phase.
//
// Optional feature (macro ME_EARLY_TERM_EN):
//   When the macro is defined, a candidate whose partial SAD reaches the
//   running best is pruned. Its remaining rows are still accepted but they
//   are not accumulated. The candidate then reports an all-ones SAD.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      one-cycle pulse; begins an operation (honoured in IDLE/DONE)
//   reuse_cur  sampled with start; 1 = skip current-block load
//   in_valid   in_data beat valid
//   in_ready   engine accepts a beat (LOAD_CUR / SEARCH)
//   in_data    one pixel row, pixel 0 in the LSBs
//   sad_valid  one-cycle pulse; sad_out/sad_pos valid
//   sad_out    SAD of the just-completed candidate
//   sad_pos    index of the just-completed candidate
//   best_sad   running minimum SAD
//   best_pos   index of best_sad
//   done       high in DONE; best_* are final
// ---------------------------------------------------------------------------

// Per-pixel absolute difference lane.
module me_sad_absdiff #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [PIX_W-1:0] d_o
);
    assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
endmodule

module me_sad_engine #(
    parameter int PIX_W    = 8,
    parameter int BLK      = 16,
    parameter int NUM_CAND = 289,
    parameter int POS_W    = 10,
    parameter int SAD_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 reuse_cur,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_W*BLK-1:0] in_data,
    output logic                 sad_valid,
    output logic [SAD_W-1:0]     sad_out,
    output logic [POS_W-1:0]     sad_pos,
    output logic [SAD_W-1:0]     best_sad,
    output logic [POS_W-1:0]     best_pos,
    output logic                 done
);
    localparam int ROW_W    = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int ROW_BITS = PIX_W * BLK;

    typedef enum logic [1:0] {S_IDLE, S_LOAD_CUR, S_SEARCH, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [ROW_W-1:0]                row_cnt_q, row_cnt_d;
    logic [POS_W-1:0]                cand_cnt_q, cand_cnt_d;
    logic [SAD_W-1:0]                acc_q, acc_d;
    logic                            sad_valid_q, sad_valid_d;
    logic [SAD_W-1:0]                sad_out_q, sad_out_d;
    logic [POS_W-1:0]                sad_pos_q, sad_pos_d;
    logic [SAD_W-1:0]                best_sad_q, best_sad_d;
    logic [POS_W-1:0]                best_pos_q, best_pos_d;
    logic [BLK-1:0][ROW_BITS-1:0]    cur_q;

    logic                            xfer;
    logic                            last_row;
    logic                            last_cand;
    logic [ROW_BITS-1:0]             cur_row;
    logic [BLK-1:0][PIX_W-1:0]       diffs;
    logic [SAD_W-1:0]                rowsum;
    logic [SAD_W-1:0]                acc_base;
    logic [SAD_W-1:0]                sum;

    assign in_ready  = (state_q == S_LOAD_CUR) || (state_q == S_SEARCH);
    assign done      = (state_q == S_DONE);
    assign xfer      = in_valid && in_ready;
    assign last_row  = (row_cnt_q == ROW_W'(BLK - 1));
    assign last_cand = (cand_cnt_q == POS_W'(NUM_CAND - 1));
    assign cur_row   = cur_q[row_cnt_q];

    // One absolute-difference lane per pixel of the row.
    for (genvar g = 0; g < BLK; g++) begin : g_lane
        me_sad_absdiff #(.PIX_W(PIX_W)) u_ad (
            .a_i (in_data[g*PIX_W +: PIX_W]),
            .b_i (cur_row[g*PIX_W +: PIX_W]),
            .d_o (diffs[g])
        );
    end

    always_comb begin
        rowsum = '0;
        for (int i = 0; i < BLK; i++) begin
            rowsum = rowsum + SAD_W'(diffs[i]);
        end
    end

    // Row 0 starts a fresh candidate, so the stale accumulator is ignored.
    assign acc_base = (row_cnt_q == '0) ? '0 : acc_q;

`ifdef ME_EARLY_TERM_EN
    logic pruned_q, pruned_d;
    logic prune_hit;
    // A pruned candidate keeps its accumulator frozen: the adder sees zero.
    assign sum       = acc_base + (pruned_q ? '0 : rowsum);
    // Partial sums never decrease, so this flag sticks once it is set.
    assign prune_hit = pruned_q || (sum >= best_sad_q);
`else
    assign sum = acc_base + rowsum;
`endif

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        cand_cnt_d  = cand_cnt_q;
        acc_d       = acc_q;
        sad_valid_d = 1'b0;
        sad_out_d   = sad_out_q;
        sad_pos_d   = sad_pos_q;
        best_sad_d  = best_sad_q;
        best_pos_d  = best_pos_q;
`ifdef ME_EARLY_TERM_EN
        pruned_d    = pruned_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    best_sad_d = '1;
                    best_pos_d = '0;
                    row_cnt_d  = '0;
                    cand_cnt_d = '0;
`ifdef ME_EARLY_TERM_EN
                    pruned_d   = 1'b0;
`endif
                    state_d    = reuse_cur ? S_SEARCH : S_LOAD_CUR;
                end
            end
            S_LOAD_CUR: begin
                if (xfer) begin
                    if (last_row) begin
                        row_cnt_d = '0;
                        state_d   = S_SEARCH;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            S_SEARCH: begin
                if (xfer) begin
                    acc_d = sum;
                    if (last_row) begin
                        row_cnt_d   = '0;
                        sad_valid_d = 1'b1;
                        sad_pos_d   = cand_cnt_q;
`ifdef ME_EARLY_TERM_EN
                        pruned_d    = 1'b0;
                        if (prune_hit) begin
                            sad_out_d = '1;
                        end else begin
                            sad_out_d  = sum;
                            best_sad_d = sum;
                            best_pos_d = cand_cnt_q;
                        end
`else
                        sad_out_d = sum;
                        // Strict compare: ties keep the earlier index.
                        if (sum < best_sad_q) begin
                            best_sad_d = sum;
                            best_pos_d = cand_cnt_q;
                        end
`endif
                        if (last_cand) begin
                            cand_cnt_d = '0;
                            state_d    = S_DONE;
                        end else begin
                            cand_cnt_d = cand_cnt_q + POS_W'(1);
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
`ifdef ME_EARLY_TERM_EN
                        pruned_d  = prune_hit;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            cand_cnt_q  <= '0;
            acc_q       <= '0;
            sad_valid_q <= 1'b0;
            sad_out_q   <= '0;
            sad_pos_q   <= '0;
            best_sad_q  <= '1;
            best_pos_q  <= '0;
`ifdef ME_EARLY_TERM_EN
            pruned_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            cand_cnt_q  <= cand_cnt_d;
            acc_q       <= acc_d;
            sad_valid_q <= sad_valid_d;
            sad_out_q   <= sad_out_d;
            sad_pos_q   <= sad_pos_d;
            best_sad_q  <= best_sad_d;
            best_pos_q  <= best_pos_d;
`ifdef ME_EARLY_TERM_EN
            pruned_q    <= pruned_d;
`endif
        end
    end

    // The current block survives reset so that a later search can reuse it.
    always_ff @(posedge clk) begin
        if (!reset && xfer && (state_q == S_LOAD_CUR)) begin
            cur_q[row_cnt_q] <= in_data;
        end
    end

    assign sad_valid = sad_valid_q;
    assign sad_out   = sad_out_q;
    assign sad_pos   = sad_pos_q;
    assign best_sad  = best_sad_q;
    assign best_pos  = best_pos_q;

endmodule

// File: tb/tb_me_sad_engine.sv
// ---------------------------------------------------------------------------
// tb_me_sad_engine -- directed self-checking bench for me_sad_engine.
// A plain-arithmetic model computes each candidate's SAD and the running
// best. A negedge compare process checks every sad_valid pulse against it.
// Literal expectations pin the model for the main scenarios.
// ---------------------------------------------------------------------------
module tb_me_sad_engine;
    localparam int PIX_W    = 8;
    localparam int BLK      = 16;
    localparam int NUM_CAND = 4;
    localparam int POS_W    = 10;
    localparam int SAD_W    = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 reuse_cur = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PIX_W*BLK-1:0] in_data = '0;
    logic                 sad_valid;
    logic [SAD_W-1:0]     sad_out;
    logic [POS_W-1:0]     sad_pos;
    logic [SAD_W-1:0]     best_sad;
    logic [POS_W-1:0]     best_pos;
    logic                 done;

    me_sad_engine #(
        .PIX_W(PIX_W), .BLK(BLK), .NUM_CAND(NUM_CAND), .POS_W(POS_W), .SAD_W(SAD_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .reuse_cur(reuse_cur),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sad_valid(sad_valid), .sad_out(sad_out), .sad_pos(sad_pos),
        .best_sad(best_sad), .best_pos(best_pos), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sad;
        int pos;
        int bsad;
        int bpos;
    } exp_t;

    exp_t exp_q[$];
    int   obs_q[$];
    int   cur_m[BLK][BLK];
    int   best_m = 65535;
    int   bpos_m = 0;
    int   cand_m = 0;
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    bit   gaps = 1'b0;
    exp_t e;

    task automatic check(input string name, input longint act, input longint expv);
        chk_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic int pix(input int base, input int mode, input int r, input int i);
        return (mode == 0) ? base : ((base + r*3 + i) % 256);
    endfunction

    function automatic int obs_at(input int k);
        return (k < obs_q.size()) ? obs_q[k] : -1;
    endfunction

    // Drive one row and hold it until the engine takes it.
    task automatic send_row(input logic [PIX_W*BLK-1:0] d);
        bit ok = 1'b0;
        logic rdy;
        if (gaps) begin
            int g = $urandom_range(0, 1) ? $urandom_range(1, 2) : 0;
            repeat (g) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        #1 in_valid = 1'b0;
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    task automatic load_cur(input int base, input int mode);
        logic [PIX_W*BLK-1:0] d;
        for (int r = 0; r < BLK; r++) begin
            for (int i = 0; i < BLK; i++) begin
                cur_m[r][i] = pix(base, mode, r, i);
                d[i*PIX_W +: PIX_W] = PIX_W'(cur_m[r][i]);
            end
            send_row(d);
        end
    endtask

    task automatic run_cand(input int base, input int mode);
        logic [PIX_W*BLK-1:0] d;
        int   sad = 0;
        int   es;
        exp_t x;
        for (int r = 0; r < BLK; r++) begin
            for (int i = 0; i < BLK; i++) begin
                int p = pix(base, mode, r, i);
                d[i*PIX_W +: PIX_W] = PIX_W'(p);
                sad += (p > cur_m[r][i]) ? (p - cur_m[r][i]) : (cur_m[r][i] - p);
            end
            send_row(d);
        end
        es = sad;
`ifdef ME_EARLY_TERM_EN
        if (sad >= best_m) es = 65535;
`endif
        if (sad < best_m) begin
            best_m = sad;
            bpos_m = cand_m;
        end
        x.sad = es; x.pos = cand_m; x.bsad = best_m; x.bpos = bpos_m;
        exp_q.push_back(x);
        cand_m++;
        if (cand_m == NUM_CAND) begin
            @(negedge clk);
            check("done_after_last", done, 1);
            check("in_ready_after_last", in_ready, 0);
        end
    endtask

    task automatic start_op(input bit r);
        @(posedge clk);
        #1 start = 1'b1; reuse_cur = r;
        @(posedge clk);
        #1 start = 1'b0; reuse_cur = 1'b0;
        best_m = 65535; bpos_m = 0; cand_m = 0;
        obs_q.delete();
        check("start_best_sad", best_sad, 65535);
        check("start_best_pos", best_pos, 0);
        check("start_done", done, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1; in_valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_best_sad", best_sad, 65535);
        check("rst_best_pos", best_pos, 0);
        check("rst_sad_valid", sad_valid, 0);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Checks every result pulse against the model.
    always @(negedge clk) begin
        if (!reset && sad_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sad_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sad_out", sad_out, e.sad);
                check("sad_pos", sad_pos, e.pos);
                check("best_sad", best_sad, e.bsad);
                check("best_pos", best_pos, e.bpos);
                obs_q.push_back(int'(sad_out));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PIX_W*BLK-1:0] d;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_best_sad", best_sad, 65535);
        check("rst_best_pos", best_pos, 0);
        check("rst_sad_out", sad_out, 0);
        check("rst_sad_pos", sad_pos, 0);
        reset = 1'b0;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_done", done, 0);
        in_valid = 1'b0;

        // Uniform block, four candidates, no gaps.
        start_op(1'b0);
        load_cur(16, 0);
        run_cand(16, 0); run_cand(18, 0); run_cand(16, 0); run_cand(15, 0);
        @(posedge clk); #1;
        check("t2_count", obs_q.size(), 4);
        check("t2_sad0", obs_at(0), 0);
`ifdef ME_EARLY_TERM_EN
        check("t2_sad1", obs_at(1), 65535);
        check("t2_sad3", obs_at(3), 65535);
`else
        check("t2_sad1", obs_at(1), 512);
        check("t2_sad2", obs_at(2), 0);
        check("t2_sad3", obs_at(3), 256);
`endif
        check("t2_best_sad", best_sad, 0);
        check("t2_best_pos", best_pos, 0);

        // Same data with random input gaps.
        gaps = 1'b1;
        start_op(1'b1);
        run_cand(16, 0); run_cand(18, 0); run_cand(16, 0); run_cand(15, 0);
        @(posedge clk); #1;
        check("t3_count", obs_q.size(), 4);
        check("t3_sad0", obs_at(0), 0);
`ifndef ME_EARLY_TERM_EN
        check("t3_sad1", obs_at(1), 512);
        check("t3_sad3", obs_at(3), 256);
`endif
        gaps = 1'b0;

        // Reuse the stored block without reloading.
        start_op(1'b1);
        for (int c = 0; c < NUM_CAND; c++) run_cand(17, 0);
        @(posedge clk); #1;
        check("t4_sad0", obs_at(0), 256);
`ifndef ME_EARLY_TERM_EN
        check("t4_sad3", obs_at(3), 256);
`endif
        check("t4_best_pos", best_pos, 0);

        // Reset in the middle of candidate 2, then restart with reuse.
        start_op(1'b1);
        run_cand(18, 0); run_cand(16, 0);
        for (int i = 0; i < BLK; i++) d[i*PIX_W +: PIX_W] = 8'h0F;
        for (int r = 0; r < 8; r++) send_row(d);
        do_reset();
        start_op(1'b1);
        run_cand(15, 0); run_cand(16, 0); run_cand(18, 0); run_cand(17, 0);
        @(posedge clk); #1;
        check("t5_sad0", obs_at(0), 256);
        check("t5_best_sad", best_sad, 0);
        check("t5_best_pos", best_pos, 1);

        // Row-varying block to exercise per-row storage.
        start_op(1'b0);
        load_cur(0, 1);
        run_cand(64, 0); run_cand(5, 1); run_cand(0, 1); run_cand(200, 0);
        @(posedge clk); #1;
        check("t6_sad0", obs_at(0), 8704);
        check("t6_sad1", obs_at(1), 1280);
        check("t6_best_pos", best_pos, 2);

        // Large-difference candidate after a good one.
        start_op(1'b0);
        load_cur(17, 0);
        run_cand(16, 0); run_cand(255, 0); run_cand(17, 0); run_cand(16, 0);
        @(posedge clk); #1;
        check("t7_sad0", obs_at(0), 256);
`ifdef ME_EARLY_TERM_EN
        check("t7_sad1", obs_at(1), 65535);
`else
        check("t7_sad1", obs_at(1), 60928);
`endif
        check("t7_best_pos", best_pos, 2);

        repeat (3) @(posedge clk); #1;
        check("pending_results", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
